// File: rtl/snes_cart_pkg.sv
// Shared types and command constants for the cartridge bus blocks.
// Covers both the ROM dump path and the flash write path.
package snes_cart_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {IDLE, WRITE, POLL, RESET_CMD, DONE, ERROR} state_e;
    typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_e;

    localparam logic [ADDR_W-1:0] CMD_ADDR1   = 20'h00555;
    localparam logic [ADDR_W-1:0] CMD_ADDR2   = 20'h002AA;
    localparam logic [DATA_W-1:0] CMD_UNLOCK1 = 8'hAA;
    localparam logic [DATA_W-1:0] CMD_UNLOCK2 = 8'h55;
    localparam logic [DATA_W-1:0] CMD_PROGRAM = 8'hA0;
    localparam logic [DATA_W-1:0] CMD_RESET   = 8'hF0;
    localparam logic [DATA_W-1:0] DQ7_MASK    = 8'h80;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_word_t;

    // Unlock/program sequence: three command writes, then the user byte.
    function automatic bus_word_t seq_word(input logic [1:0] idx,
                                           input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] data);
        bus_word_t w;
        unique case (idx)
            2'd0:    w = '{addr: CMD_ADDR1, data: CMD_UNLOCK1};
            2'd1:    w = '{addr: CMD_ADDR2, data: CMD_UNLOCK2};
            2'd2:    w = '{addr: CMD_ADDR1, data: CMD_PROGRAM};
            default: w = '{addr: addr, data: data};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/snes_flash_writer_if.sv
// Host-side request/status bundle for the flash writer.
interface snes_flash_writer_if;
    logic                            wr_valid;
    logic                            wr_ready;
    logic [snes_cart_pkg::ADDR_W-1:0] wr_addr;
    logic [snes_cart_pkg::DATA_W-1:0] wr_data;
    logic                            done;
    logic                            error;
    logic                            busy;

    modport master (output wr_valid, wr_addr, wr_data,
                    input  wr_ready, done, error, busy);
    modport slave  (input  wr_valid, wr_addr, wr_data,
                    output wr_ready, done, error, busy);
endinterface

// File: rtl/snes_bus_cycle.sv
// One cartridge bus cycle: write (setup/strobe/hold) or read (oe pulse/recovery).
// A start on the final hold cycle chains the next cycle with no idle gap.
module snes_bus_cycle
    import snes_cart_pkg::*;
#(
    parameter logic [2:0] SETUP_CYCLES = 3'd1,
    parameter logic [2:0] PULSE_CYCLES = 3'd3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] data_in,
    output logic              we_n,
    output logic              oe_n,
    output logic              data_oe,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] rd_data,
    output logic              cycle_done
);

    logic              active_q, active_d;
    phase_e            phase_q, phase_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 1'b0;
            phase_q   <= SETUP;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
        end else begin
            active_q  <= active_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        active_d  = active_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
        if (active_q) begin
            unique case (phase_q)
                SETUP: begin
                    if (cnt_q == SETUP_CYCLES - 3'd1) begin
                        phase_d = STROBE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                STROBE: begin
                    if (cnt_q == PULSE_CYCLES - 3'd1) begin
                        phase_d = HOLD;
                        cnt_d   = '0;
                        // Flash data is sampled on the last oe_n-low cycle.
                        if (rd_q) rd_data_d = data_in;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: active_d = 1'b0;
            endcase
        end
        if (start) begin
            active_d = 1'b1;
            rd_d     = is_read;
            addr_d   = addr;
            data_d   = data;
            cnt_d    = '0;
            phase_d  = is_read ? STROBE : SETUP;
        end
    end

    assign cycle_done = active_q && (phase_q == HOLD);
    assign we_n       = !(active_q && !rd_q && (phase_q == STROBE));
    assign oe_n       = !(active_q && rd_q && (phase_q == STROBE));
    assign data_oe    = active_q && !rd_q;
    assign address    = addr_q;
    assign data_out   = data_q;
    assign rd_data    = rd_data_q;

endmodule

// File: rtl/snes_flash_writer.sv
// Byte programmer for JEDEC/AMD-style flash on the cartridge bus:
// unlock + program command writes, data write, then DQ7 polling with timeout.
module snes_flash_writer
    import snes_cart_pkg::*;
#(
    parameter logic [2:0]  SETUP_CYCLES = 3'd1,
    parameter logic [2:0]  PULSE_CYCLES = 3'd3,
    parameter logic [15:0] POLL_LIMIT   = 16'd4096
) (
    input  logic               clk,
    input  logic               reset,
    snes_flash_writer_if.slave host,
    output logic [ADDR_W-1:0]  address,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_oe,
    input  logic [DATA_W-1:0]  data_in,
    output logic               ce_n,
    output logic               we_n,
    output logic               oe_n
);

    state_e            state_q, state_d;
    logic [1:0]        seq_q, seq_d;
    logic [15:0]       poll_cnt_q, poll_cnt_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_data_q, lat_data_d;

    logic              bus_start, bus_read, bus_done;
    bus_word_t         bus_word;
    logic [DATA_W-1:0] bus_rd_data;

    snes_bus_cycle #(
        .SETUP_CYCLES(SETUP_CYCLES),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_bus (
        .clk       (clk),
        .reset     (reset),
        .start     (bus_start),
        .is_read   (bus_read),
        .addr      (bus_word.addr),
        .data      (bus_word.data),
        .data_in   (data_in),
        .we_n      (we_n),
        .oe_n      (oe_n),
        .data_oe   (data_oe),
        .address   (address),
        .data_out  (data_out),
        .rd_data   (bus_rd_data),
        .cycle_done(bus_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            seq_q      <= '0;
            poll_cnt_q <= '0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            poll_cnt_q <= poll_cnt_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        poll_cnt_d = poll_cnt_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        bus_start  = 1'b0;
        bus_read   = 1'b0;
        bus_word   = '{addr: lat_addr_q, data: lat_data_q};
        unique case (state_q)
            IDLE: begin
                if (host.wr_valid) begin
                    lat_addr_d = host.wr_addr;
                    lat_data_d = host.wr_data;
                    seq_d      = 2'd0;
                    bus_start  = 1'b1;
                    bus_word   = seq_word(2'd0, host.wr_addr, host.wr_data);
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (bus_done) begin
                    bus_start = 1'b1;
                    if (seq_q == 2'd3) begin
                        bus_read   = 1'b1;
                        poll_cnt_d = '0;
                        state_d    = POLL;
                    end else begin
                        seq_d    = seq_q + 2'd1;
                        bus_word = seq_word(seq_q + 2'd1, lat_addr_q, lat_data_q);
                    end
                end
            end
            POLL: begin
                if (bus_done) begin
                    if (((bus_rd_data ^ lat_data_q) & DQ7_MASK) == '0) begin
                        state_d = DONE;
                    end else if (poll_cnt_q + 16'd1 == POLL_LIMIT) begin
                        // Give up: return the chip to read-array mode before flagging.
                        poll_cnt_d = POLL_LIMIT;
                        bus_start  = 1'b1;
                        bus_word   = '{addr: '0, data: CMD_RESET};
                        state_d    = RESET_CMD;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                        bus_start  = 1'b1;
                        bus_read   = 1'b1;
                    end
                end
            end
            RESET_CMD: if (bus_done) state_d = ERROR;
            default:   state_d = IDLE;
        endcase
    end

    assign host.wr_ready = (state_q == IDLE);
    assign host.busy     = (state_q != IDLE);
    assign host.done     = (state_q == DONE);
    assign host.error    = (state_q == ERROR);
    assign ce_n          = !(state_q inside {WRITE, POLL, RESET_CMD});

    assert property (@(posedge clk) disable iff (reset) !(data_oe && !oe_n));

endmodule

// File: tb/tb_snes_flash_writer.sv
// Bench for snes_flash_writer: two instances (default timing, and SETUP=3/PULSE=1/POLL_LIMIT=4)
// share a bus monitor and a DQ7 flash model; expectations come from the command-sequence rules.
module tb_snes_flash_writer;
    import snes_cart_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic h_valid = 1'b0;
    logic [19:0] h_addr = '0;
    logic [7:0]  h_data = '0;
    logic [7:0]  data_in;

    logic [19:0] addr0, addr1;
    logic [7:0]  dout0, dout1;
    logic doe0, doe1, ce0, ce1, we0, we1, oe0, oe1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    snes_flash_writer_if if0();
    snes_flash_writer_if if1();
    assign if0.wr_valid = h_valid && !sel;
    assign if1.wr_valid = h_valid && sel;
    assign if0.wr_addr  = h_addr;
    assign if1.wr_addr  = h_addr;
    assign if0.wr_data  = h_data;
    assign if1.wr_data  = h_data;

    snes_flash_writer dut0 (
        .clk(clk), .reset(reset), .host(if0), .address(addr0), .data_out(dout0),
        .data_oe(doe0), .data_in(data_in), .ce_n(ce0), .we_n(we0), .oe_n(oe0));

    snes_flash_writer #(.SETUP_CYCLES(3'd3), .PULSE_CYCLES(3'd1), .POLL_LIMIT(16'd4)) dut1 (
        .clk(clk), .reset(reset), .host(if1), .address(addr1), .data_out(dout1),
        .data_oe(doe1), .data_in(data_in), .ce_n(ce1), .we_n(we1), .oe_n(oe1));

    // Selected-instance view
    logic [19:0] m_address;
    logic [7:0]  m_data_out;
    logic m_data_oe, m_ce_n, m_we_n, m_oe_n, m_ready, m_busy, m_done, m_error, m_valid;
    assign m_address  = sel ? addr1 : addr0;
    assign m_data_out = sel ? dout1 : dout0;
    assign m_data_oe  = sel ? doe1 : doe0;
    assign m_ce_n     = sel ? ce1 : ce0;
    assign m_we_n     = sel ? we1 : we0;
    assign m_oe_n     = sel ? oe1 : oe0;
    assign m_ready    = sel ? if1.wr_ready : if0.wr_ready;
    assign m_busy     = sel ? if1.busy : if0.busy;
    assign m_done     = sel ? if1.done : if0.done;
    assign m_error    = sel ? if1.error : if0.error;
    assign m_valid    = sel ? if1.wr_valid : if0.wr_valid;

    // Flash model: DQ7 mismatches for the first n_fail polls of a request
    int poll_base = 0;
    int n_fail = 0;
    int mon_polls = 0;
    logic [7:0] fail_val = '0, match_val = '0;
    assign data_in = ((mon_polls - poll_base) < n_fail) ? fail_val : match_val;

    int cyc = 0;
    logic [27:0] wr_q[$];
    int wr_len[$], wr_fall[$], poll_len[$], poll_st[$], done_st[$], err_st[$], acc_q[$];
    logic done_ce[$];
    logic [19:0] acc_a[$];
    int both_cnt = 0, conflict_cnt = 0, we_lo = 0, oe_lo = 0;
    logic prev_we = 1'b1, prev_oe = 1'b1;
    logic [27:0] cap_w = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset && m_valid && m_ready) begin
            acc_q.push_back(cyc);
            acc_a.push_back(h_addr);
        end
    end

    always @(negedge clk) begin
        if (prev_we && !m_we_n) wr_fall.push_back(cyc);
        if (!m_we_n) begin
            we_lo = we_lo + 1;
            cap_w = {m_address, m_data_out};
        end
        if (!prev_we && m_we_n) begin
            wr_q.push_back(cap_w);
            wr_len.push_back(we_lo);
            we_lo = 0;
        end
        if (prev_oe && !m_oe_n) poll_st.push_back(cyc);
        if (!m_oe_n) oe_lo = oe_lo + 1;
        if (!prev_oe && m_oe_n) begin
            poll_len.push_back(oe_lo);
            oe_lo = 0;
            mon_polls = mon_polls + 1;
        end
        if (m_done) begin
            done_st.push_back(cyc);
            done_ce.push_back(m_ce_n);
        end
        if (m_error) err_st.push_back(cyc);
        if (m_done && m_error) both_cnt = both_cnt + 1;
        if (m_data_oe && !m_oe_n) conflict_cnt = conflict_cnt + 1;
        prev_we = m_we_n;
        prev_oe = m_oe_n;
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (m_ready !== 1'b1)     begin n_bad++; $display("FAIL reset wr_ready got %b want 1", m_ready); end
        n_cmp++; if (m_busy !== 1'b0)      begin n_bad++; $display("FAIL reset busy got %b want 0", m_busy); end
        n_cmp++; if (m_done !== 1'b0)      begin n_bad++; $display("FAIL reset done got %b want 0", m_done); end
        n_cmp++; if (m_error !== 1'b0)     begin n_bad++; $display("FAIL reset error got %b want 0", m_error); end
        n_cmp++; if (m_ce_n !== 1'b1)      begin n_bad++; $display("FAIL reset ce_n got %b want 1", m_ce_n); end
        n_cmp++; if (m_we_n !== 1'b1)      begin n_bad++; $display("FAIL reset we_n got %b want 1", m_we_n); end
        n_cmp++; if (m_oe_n !== 1'b1)      begin n_bad++; $display("FAIL reset oe_n got %b want 1", m_oe_n); end
        n_cmp++; if (m_data_oe !== 1'b0)   begin n_bad++; $display("FAIL reset data_oe got %b want 0", m_data_oe); end
        n_cmp++; if (m_address !== 20'h0)  begin n_bad++; $display("FAIL reset address got %h want 00000", m_address); end
        n_cmp++; if (m_data_out !== 8'h0)  begin n_bad++; $display("FAIL reset data_out got %h want 00", m_data_out); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_program(input logic s, input logic [19:0] a, input logic [7:0] d,
                                input int nf, input string name);
        int sc, pc, w, lim, npoll, a0, w0, p0, d0, e0, b0, c0, acc, budget, ef;
        logic to;
        logic [27:0] exp_w[$];
        sc = s ? 3 : 1;
        pc = s ? 1 : 3;
        lim = s ? 4 : 4096;
        w = sc + pc + 1;
        to = (nf >= lim);
        npoll = to ? lim : nf + 1;
        exp_w.push_back({20'h00555, 8'hAA});
        exp_w.push_back({20'h002AA, 8'h55});
        exp_w.push_back({20'h00555, 8'hA0});
        exp_w.push_back({a, d});
        if (to) exp_w.push_back({20'h00000, 8'hF0});
        a0 = acc_q.size(); w0 = wr_q.size(); p0 = poll_st.size();
        d0 = done_st.size(); e0 = err_st.size(); b0 = both_cnt; c0 = conflict_cnt;
        poll_base = mon_polls;
        n_fail = nf;
        match_val = {d[7], 7'($urandom)};
        fail_val = {~d[7], 7'($urandom)};
        @(negedge clk);
        sel = s; h_addr = a; h_data = d; h_valid = 1'b1;
        @(negedge clk);
        h_valid = 1'b0;
        budget = 4 * w + npoll * (pc + 1) + w + 40;
        for (int i = 0; i < budget; i++) begin
            if (done_st.size() > d0 || err_st.size() > e0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (acc_q.size() != a0 + 1) begin
            n_bad++; $display("FAIL %s accepts got %0d want 1", name, acc_q.size() - a0);
        end
        acc = (acc_q.size() > a0) ? acc_q[a0] : 0;
        n_cmp++;
        if (wr_q.size() - w0 != exp_w.size()) begin
            n_bad++; $display("FAIL %s write count got %0d want %0d", name, wr_q.size() - w0, exp_w.size());
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            if (w0 + i < wr_q.size()) begin
                ef = (i < 4) ? acc + sc + i * w : acc + 4 * w + lim * (pc + 1) + sc;
                n_cmp++; if (wr_q[w0 + i] !== exp_w[i]) begin n_bad++; $display("FAIL %s write%0d addr/data got %h want %h", name, i, wr_q[w0 + i], exp_w[i]); end
                n_cmp++; if (wr_len[w0 + i] != pc) begin n_bad++; $display("FAIL %s write%0d we_n low got %0d want %0d", name, i, wr_len[w0 + i], pc); end
                n_cmp++; if (wr_fall[w0 + i] != ef) begin n_bad++; $display("FAIL %s write%0d strobe cycle got %0d want %0d", name, i, wr_fall[w0 + i] - acc, ef - acc); end
            end
        end
        n_cmp++;
        if (mon_polls - poll_base != npoll) begin
            n_bad++; $display("FAIL %s polls got %0d want %0d", name, mon_polls - poll_base, npoll);
        end
        for (int j = 0; j < npoll; j++) begin
            if (p0 + j < poll_st.size()) begin
                n_cmp++; if (poll_len[p0 + j] != pc) begin n_bad++; $display("FAIL %s poll%0d oe_n low got %0d want %0d", name, j, poll_len[p0 + j], pc); end
                n_cmp++; if (poll_st[p0 + j] != acc + 4 * w + j * (pc + 1)) begin n_bad++; $display("FAIL %s poll%0d start got %0d want %0d", name, j, poll_st[p0 + j] - acc, 4 * w + j * (pc + 1)); end
            end
        end
        n_cmp++; if (done_st.size() - d0 != (to ? 0 : 1)) begin n_bad++; $display("FAIL %s done pulses got %0d want %0d", name, done_st.size() - d0, to ? 0 : 1); end
        n_cmp++; if (err_st.size() - e0 != (to ? 1 : 0)) begin n_bad++; $display("FAIL %s error pulses got %0d want %0d", name, err_st.size() - e0, to ? 1 : 0); end
        if (!to && done_st.size() > d0) begin
            n_cmp++; if (done_st[d0] != acc + 4 * w + npoll * (pc + 1)) begin n_bad++; $display("FAIL %s done cycle got %0d want %0d", name, done_st[d0] - acc, 4 * w + npoll * (pc + 1)); end
            n_cmp++; if (done_ce[d0] !== 1'b1) begin n_bad++; $display("FAIL %s ce_n at done got %b want 1", name, done_ce[d0]); end
        end
        if (to && err_st.size() > e0) begin
            n_cmp++; if (err_st[e0] != acc + 4 * w + lim * (pc + 1) + w) begin n_bad++; $display("FAIL %s error cycle got %0d want %0d", name, err_st[e0] - acc, 4 * w + lim * (pc + 1) + w); end
        end
        n_cmp++; if (both_cnt != b0) begin n_bad++; $display("FAIL %s done&error overlap got %0d want 0", name, both_cnt - b0); end
        n_cmp++; if (conflict_cnt != c0) begin n_bad++; $display("FAIL %s data_oe with oe_n low got %0d want 0", name, conflict_cnt - c0); end
    endtask

    task automatic test_reset_mid();
        int a0, w0, d0, e0, acc, target, f0_hits;
        a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_st.size(); e0 = err_st.size();
        poll_base = mon_polls; n_fail = 0;
        @(negedge clk);
        sel = 1'b0; h_addr = 20'($urandom); h_data = 8'($urandom); h_valid = 1'b1;
        @(negedge clk);
        h_valid = 1'b0;
        acc = (acc_q.size() > a0) ? acc_q[a0] : cyc;
        target = acc + 1 + 2 * 5;
        while (cyc < target) @(negedge clk);
        n_cmp++; if (m_we_n !== 1'b0) begin n_bad++; $display("FAIL reset_mid strobe2 we_n got %b want 0", m_we_n); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (m_we_n !== 1'b1)    begin n_bad++; $display("FAIL reset_mid we_n got %b want 1", m_we_n); end
        n_cmp++; if (m_ce_n !== 1'b1)    begin n_bad++; $display("FAIL reset_mid ce_n got %b want 1", m_ce_n); end
        n_cmp++; if (m_data_oe !== 1'b0) begin n_bad++; $display("FAIL reset_mid data_oe got %b want 0", m_data_oe); end
        n_cmp++; if (m_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_mid wr_ready got %b want 1", m_ready); end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        f0_hits = 0;
        for (int i = w0; i < wr_q.size(); i++) if (wr_q[i][7:0] == 8'hF0) f0_hits++;
        n_cmp++; if (wr_q.size() - w0 != 3) begin n_bad++; $display("FAIL reset_mid strobes got %0d want 3", wr_q.size() - w0); end
        n_cmp++; if (f0_hits != 0) begin n_bad++; $display("FAIL reset_mid F0 writes got %0d want 0", f0_hits); end
        n_cmp++; if (done_st.size() != d0 || err_st.size() != e0) begin n_bad++; $display("FAIL reset_mid pulses got %0d want 0", done_st.size() - d0 + err_st.size() - e0); end
        n_cmp++; if (mon_polls != poll_base) begin n_bad++; $display("FAIL reset_mid polls got %0d want 0", mon_polls - poll_base); end
    endtask

    task automatic test_back_to_back();
        int a0, w0, d0;
        logic [19:0] ad1, ad2;
        logic [7:0]  dt1, dt2;
        ad1 = 20'($urandom); ad2 = 20'($urandom);
        dt1 = 8'($urandom); dt2 = {dt1[7], 7'($urandom)};
        a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_st.size();
        poll_base = mon_polls; n_fail = 0;
        match_val = {dt1[7], 7'($urandom)}; fail_val = ~match_val;
        @(negedge clk);
        sel = 1'b0; h_addr = ad1; h_data = dt1; h_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (acc_q.size() > a0) break;
        end
        h_addr = ad2; h_data = dt2;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (acc_q.size() > a0 + 1) break;
        end
        h_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done_st.size() > d0 + 1) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (acc_q.size() - a0 != 2) begin n_bad++; $display("FAIL b2b accepts got %0d want 2", acc_q.size() - a0); end
        n_cmp++; if (done_st.size() - d0 != 2) begin n_bad++; $display("FAIL b2b done pulses got %0d want 2", done_st.size() - d0); end
        if (acc_q.size() - a0 >= 2 && done_st.size() > d0) begin
            n_cmp++; if (acc_q[a0 + 1] != done_st[d0] + 2) begin n_bad++; $display("FAIL b2b second accept got %0d want %0d", acc_q[a0 + 1], done_st[d0] + 2); end
            n_cmp++; if (done_ce[d0] !== 1'b1) begin n_bad++; $display("FAIL b2b ce_n gap got %b want 1", done_ce[d0]); end
            n_cmp++; if (acc_a[a0 + 1] !== ad2) begin n_bad++; $display("FAIL b2b second addr got %h want %h", acc_a[a0 + 1], ad2); end
        end
        n_cmp++; if (wr_q.size() - w0 != 8) begin n_bad++; $display("FAIL b2b writes got %0d want 8", wr_q.size() - w0); end
        if (wr_q.size() - w0 >= 8) begin
            n_cmp++; if (wr_q[w0 + 3] !== {ad1, dt1}) begin n_bad++; $display("FAIL b2b data write1 got %h want %h", wr_q[w0 + 3], {ad1, dt1}); end
            n_cmp++; if (wr_q[w0 + 7] !== {ad2, dt2}) begin n_bad++; $display("FAIL b2b data write2 got %h want %h", wr_q[w0 + 7], {ad2, dt2}); end
        end
    endtask

    task automatic test_random();
        logic s;
        for (int k = 0; k < 6; k++) begin
            s = 1'($urandom_range(0, 1));
            test_program(s, 20'($urandom), 8'($urandom), int'($urandom_range(0, 5)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_program(1'b0, 20'h1A2B3, 8'h5C, 0, "normal");
        test_program(1'b0, 20'($urandom), 8'h80, 5, "delayed");
        test_program(1'b1, 20'($urandom), 8'($urandom), 100, "timeout");
        test_program(1'b1, 20'($urandom), 8'($urandom), 1, "sweep");
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
